// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, control-vector bit positions and ALU codes
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 7;
  localparam int SHAMT_W = 5;

  // bit positions in {reg_write,mem_to_reg,mem_read,mem_write,branch,reg_dst,alu_src}
  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_REG_DST    = 1;
  localparam int CTRL_ALU_SRC    = 0;

  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// rtl/id_ex_stage_fwd_unit.sv - combinational RAW bypass for one source operand
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] reg_num,
  input  logic [DW-1:0] reg_data,
  input  logic          exm_wr,
  input  logic [AW-1:0] exm_rd,
  input  logic [DW-1:0] exm_res,
  input  logic          mwb_wr,
  input  logic [AW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_res,
  output logic [DW-1:0] fwd_data
);

  // the younger EX/MEM result wins; r0 is hardwired zero and never bypassed
  always_comb begin
    fwd_data = reg_data;
    if (exm_wr && (exm_rd != '0) && (exm_rd == reg_num))
      fwd_data = exm_res;
    else if (mwb_wr && (mwb_rd != '0) && (mwb_rd == reg_num))
      fwd_data = mwb_res;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detect
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  logic [CTRL_W-1:0]   id_ctrl_i,
  input  logic [3:0]          id_alu_ctrl_i,
  input  logic [DW-1:0]       id_rs_data_i,
  input  logic [DW-1:0]       id_rt_data_i,
  input  logic [DW-1:0]       id_imm_i,
  input  logic [SHAMT_W-1:0]  id_shamt_i,
  input  logic [AW-1:0]       id_rs_i,
  input  logic [AW-1:0]       id_rt_i,
  input  logic [AW-1:0]       id_rd_i,
  input  logic                exm_wr_i,
  input  logic [AW-1:0]       exm_rd_i,
  input  logic [DW-1:0]       exm_res_i,
  input  logic                mwb_wr_i,
  input  logic [AW-1:0]       mwb_rd_i,
  input  logic [DW-1:0]       mwb_res_i,
  output logic [DW-1:0]       alu_src1_o,
  output logic [DW-1:0]       alu_src2_o,
  output logic [3:0]          alu_ctrl_o,
  output logic [CTRL_W-1:0]   ex_ctrl_o,
  output logic [DW-1:0]       ex_wdata_o,
  output logic [AW-1:0]       ex_wreg_o,
  output logic                ex_valid_o,
  output logic                ld_use_o
);

  logic               ex_valid;
  logic [CTRL_W-1:0]  ex_ctrl;
  logic [3:0]         ex_alu_ctrl;
  logic [DW-1:0]      ex_rs_data;
  logic [DW-1:0]      ex_rt_data;
  logic [DW-1:0]      ex_imm;
  logic [SHAMT_W-1:0] ex_shamt;
  logic [AW-1:0]      ex_rs;
  logic [AW-1:0]      ex_rt;
  logic [AW-1:0]      ex_rd;
  logic [DW-1:0]      fwd_rs;
  logic [DW-1:0]      fwd_rt;

  // flush only needs to kill valid and control; data fields of a bubble are never used
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_alu_ctrl <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_shamt    <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
    end else if (flush_i) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (!stall_i) begin
      ex_valid    <= id_valid_i;
      ex_ctrl     <= id_valid_i ? id_ctrl_i : '0;
      ex_alu_ctrl <= id_alu_ctrl_i;
      ex_rs_data  <= id_rs_data_i;
      ex_rt_data  <= id_rt_data_i;
      ex_imm      <= id_imm_i;
      ex_shamt    <= id_shamt_i;
      ex_rs       <= id_rs_i;
      ex_rt       <= id_rt_i;
      ex_rd       <= id_rd_i;
    end
  end

  fwd_unit #(.DW(DW), .AW(AW)) u_fwd_rs (
    .reg_num (ex_rs),
    .reg_data(ex_rs_data),
    .exm_wr  (exm_wr_i),
    .exm_rd  (exm_rd_i),
    .exm_res (exm_res_i),
    .mwb_wr  (mwb_wr_i),
    .mwb_rd  (mwb_rd_i),
    .mwb_res (mwb_res_i),
    .fwd_data(fwd_rs)
  );

  fwd_unit #(.DW(DW), .AW(AW)) u_fwd_rt (
    .reg_num (ex_rt),
    .reg_data(ex_rt_data),
    .exm_wr  (exm_wr_i),
    .exm_rd  (exm_rd_i),
    .exm_res (exm_res_i),
    .mwb_wr  (mwb_wr_i),
    .mwb_rd  (mwb_rd_i),
    .mwb_res (mwb_res_i),
    .fwd_data(fwd_rt)
  );

  assign alu_src1_o = (ex_alu_ctrl == ALU_SRA) ? {{(DW-SHAMT_W){1'b0}}, ex_shamt} : fwd_rs;
  assign alu_src2_o = ex_ctrl[CTRL_ALU_SRC] ? ex_imm : fwd_rt;
  assign alu_ctrl_o = ex_alu_ctrl;
  assign ex_ctrl_o  = ex_ctrl;
  assign ex_wdata_o = fwd_rt;
  assign ex_wreg_o  = ex_ctrl[CTRL_REG_DST] ? ex_rd : ex_rt;
  assign ex_valid_o = ex_valid;

  // a load in EX cannot supply its data until MEM, so a dependent ID instruction must wait
  assign ld_use_o = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rt != '0) && id_valid_i &&
                    ((ex_rt == id_rs_i) || (ex_rt == id_rt_i));

endmodule
